// File: rtl/boot_pkg.sv
// Shared types and constants for the boot stream loader: FSM states and
// word/byte geometry of the instruction stream.
package boot_pkg;

    localparam int BOOT_WORD_W         = 32;
    localparam int BOOT_BYTES_PER_WORD = 4;
    localparam int BOOT_WORDS          = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        FINISH
    } boot_state_e;

endpackage

// File: rtl/boot_byte_packer.sv
// Shifts instruction bytes MSB-first into a 32-bit word and flags the
// handshake that completes the word.
module boot_byte_packer
    import boot_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   shift,
    input  logic [7:0]             byte_data,
    output logic [BOOT_WORD_W-1:0] word_next,
    output logic                   full
);

    localparam int                CNT_W     = $clog2(BOOT_BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BOOT_BYTES_PER_WORD - 1);

    logic [BOOT_WORD_W-1:0] word_buf;
    logic [CNT_W-1:0]       byte_cnt;

    // word_next is the buffer as it will look after this edge, so the loader
    // can capture a finished word in the same cycle as its last byte.
    assign word_next = shift ? {word_buf[BOOT_WORD_W-9:0], byte_data} : word_buf;
    assign full      = shift && (byte_cnt == LAST_BYTE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_buf <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word_buf <= '0;
            byte_cnt <= '0;
        end else if (shift) begin
            word_buf <= word_next;
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/boot_stream_loader.sv
// Packs a byte stream into 32-bit words and writes them through the CPU boot
// port at consecutive addresses, then releases boot_up and pulses done.
module boot_stream_loader
    import boot_pkg::*;
#(
    parameter int WORDS  = BOOT_WORDS,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   boot_up,
    output logic [ADDR_W-1:0]      boot_addr,
    output logic [BOOT_WORD_W-1:0] boot_datai,
    output logic                   boot_web,
    output logic                   done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

    boot_state_e            state, state_nxt;
    logic [ADDR_W-1:0]      word_idx, word_idx_nxt, addr_nxt;
    logic [BOOT_WORD_W-1:0] datai_nxt, word_next;
    logic                   clear, shift, full;

    assign shift = byte_valid && byte_ready;

    boot_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .shift     (shift),
        .byte_data (byte_data),
        .word_next (word_next),
        .full      (full)
    );

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        word_idx_nxt = word_idx;
        clear        = 1'b0;
        addr_nxt     = boot_addr;
        datai_nxt    = boot_datai;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = LOAD;
                    word_idx_nxt = '0;
                    clear        = 1'b1;
                end
            end
            LOAD: begin
                if (full) state_nxt = WRITE;
            end
            WRITE: begin
                if (word_idx == LAST_IDX) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt    = LOAD;
                    word_idx_nxt = word_idx + 1'b1;
                    clear        = 1'b1;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave flops aligned
        // with the state they describe.
        case (state_nxt)
            WRITE: begin
                addr_nxt  = word_idx;
                datai_nxt = word_next;
            end
            LOAD: begin
            end
            default: begin
                addr_nxt  = '0;
                datai_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_idx   <= '0;
            byte_ready <= 1'b0;
            boot_up    <= 1'b0;
            boot_web   <= 1'b1;
            boot_addr  <= '0;
            boot_datai <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            word_idx   <= word_idx_nxt;
            byte_ready <= (state_nxt == LOAD);
            boot_up    <= (state_nxt != IDLE);
            boot_web   <= (state_nxt != WRITE);
            boot_addr  <= addr_nxt;
            boot_datai <= datai_nxt;
            done       <= (state == FINISH);
        end
    end

endmodule

// File: tb/tb_boot_stream_loader.sv
// Directed bench: a 32-word loader and a 1-word loader share clock and reset.
module tb_boot_stream_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start0 = 1'b0, valid0 = 1'b0;
    logic [7:0]  data0 = 8'h00;
    logic        ready0, up0, web0, done0;
    logic [7:0]  addr0;
    logic [31:0] datai0;

    logic        start1 = 1'b0, valid1 = 1'b0;
    logic [7:0]  data1 = 8'h00;
    logic        ready1, up1, web1, done1;
    logic [7:0]  addr1;
    logic [31:0] datai1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    boot_stream_loader #(.WORDS(32), .ADDR_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .byte_valid(valid0), .byte_data(data0),
        .byte_ready(ready0), .boot_up(up0), .boot_addr(addr0), .boot_datai(datai0),
        .boot_web(web0), .done(done0)
    );

    boot_stream_loader #(.WORDS(1), .ADDR_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .byte_valid(valid1), .byte_data(data1),
        .byte_ready(ready1), .boot_up(up1), .boot_addr(addr1), .boot_datai(datai1),
        .boot_web(web1), .done(done1)
    );

    // Write/done monitors, sampled mid-cycle
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          up_cycles = 0, done_cnt = 0, done_cyc = 0;
    int          hs4[32];

    int          w1_cnt = 0, w1_cyc = 0, d1_cnt = 0;
    logic [7:0]  w1_addr = 8'h00;
    logic [31:0] w1_data = 32'h0;

    always @(negedge clk) begin
        if (!web0) begin
            wr_addr.push_back(addr0);
            wr_data.push_back(datai0);
            wr_cyc.push_back(cyc);
        end
        if (up0) up_cycles++;
        if (done0) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!web1) begin
            w1_cnt++;
            w1_addr = addr1;
            w1_data = datai1;
            w1_cyc  = cyc;
        end
        if (done1) d1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] b_of(input int n);
        if (n == 3) return 8'h0F;
        if (n < 3)  return 8'h00;
        return 8'((n * 13 + 5) & 255);
    endfunction

    function automatic logic [31:0] word_of(input int k);
        return {b_of(4*k), b_of(4*k+1), b_of(4*k+2), b_of(4*k+3)};
    endfunction

    task automatic clear_mon0();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        up_cycles = 0;
        done_cnt  = 0;
        done_cyc  = 0;
    endtask

    // Called #1 after an edge; returns the cycle stamp of the edge that saw start.
    task automatic pulse_start(input bit sel, output int sc);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        if (sel) start1 = 1'b0; else start0 = 1'b0;
        sc = cyc;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] d, input bit throttle, output int hs_cyc);
        int guard;
        if (throttle) begin
            while ($urandom_range(0, 2) == 0) begin
                if (sel) valid1 = 1'b0; else valid0 = 1'b0;
                @(posedge clk); #1;
            end
        end
        if (sel) begin valid1 = 1'b1; data1 = d; end
        else     begin valid0 = 1'b1; data0 = d; end
        guard = 0;
        while (!(sel ? ready1 : ready0) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) check("ready_timeout", 32'(guard), 32'd0);
        @(posedge clk); #1;
        hs_cyc = cyc;
        if (sel) valid1 = 1'b0; else valid0 = 1'b0;
    endtask

    task automatic load0(input bit throttle);
        int h;
        for (int n = 0; n < 128; n++) begin
            send_byte(1'b0, b_of(n), throttle, h);
            if (n % 4 == 3) hs4[n/4] = h;
        end
    endtask

    task automatic wait_done(input bit sel, output int dc);
        int guard;
        guard = 0;
        while (!(sel ? done1 : done0) && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 400) check("done_timeout", 32'(guard), 32'd0);
        dc = cyc;
    endtask

    // mode 0: back-to-back timing; mode 1: write follows each 4th handshake
    task automatic verify0(input string tag, input int sc, input bit mode);
        int n;
        n = (wr_addr.size() < 32) ? wr_addr.size() : 32;
        check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd32);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_addr[%0d]", tag, k), 32'(wr_addr[k]), 32'(k));
            check($sformatf("%s_data[%0d]", tag, k), wr_data[k], word_of(k));
            if (mode) check($sformatf("%s_wcyc[%0d]", tag, k), 32'(wr_cyc[k]), 32'(hs4[k]));
            else      check($sformatf("%s_wcyc[%0d]", tag, k), 32'(wr_cyc[k]), 32'(sc + 4 + 5*k));
        end
        if (n >= 2) begin
            check({tag, "_word0"}, wr_data[0], 32'h0000000F);
            check({tag, "_word1"}, wr_data[1], 32'h39465360);
        end
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        if (!mode) begin
            check({tag, "_done_cyc"}, 32'(done_cyc), 32'(sc + 161));
            check({tag, "_up_cycles"}, 32'(up_cycles), 32'd161);
        end
        check({tag, "_idle_up"}, 32'(up0), 32'd0);
        check({tag, "_idle_web"}, 32'(web0), 32'd1);
        check({tag, "_idle_addr"}, 32'(addr0), 32'd0);
        check({tag, "_idle_data"}, datai0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, sc2, dc, h;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_up", 32'(up0), 32'd0);
        check("rst_web", 32'(web0), 32'd1);
        check("rst_addr", 32'(addr0), 32'd0);
        check("rst_data", datai0, 32'd0);
        check("rst_ready", 32'(ready0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal back-to-back load
        clear_mon0();
        pulse_start(1'b0, sc);
        check("nom_up_after_start", 32'(up0), 32'd1);
        check("nom_ready_after_start", 32'(ready0), 32'd1);
        load0(1'b0);
        wait_done(1'b0, dc);
        @(posedge clk); #1;
        verify0("nom", sc, 1'b0);

        // Throttled upstream
        clear_mon0();
        pulse_start(1'b0, sc);
        load0(1'b1);
        wait_done(1'b0, dc);
        @(posedge clk); #1;
        verify0("thr", sc, 1'b1);

        // start pulsed during LOAD and during WRITE of word 1
        clear_mon0();
        pulse_start(1'b0, sc);
        fork
            load0(1'b0);
            begin
                @(posedge clk); #1;
                start0 = 1'b1;
                @(posedge clk); #1;
                start0 = 1'b0;
                repeat (7) @(posedge clk);
                #1;
                start0 = 1'b1;
                @(posedge clk); #1;
                start0 = 1'b0;
            end
        join
        wait_done(1'b0, dc);
        @(posedge clk); #1;
        verify0("ign", sc, 1'b0);

        // Reset after two bytes of word 5
        clear_mon0();
        pulse_start(1'b0, sc);
        for (int n = 0; n < 22; n++) send_byte(1'b0, b_of(n), 1'b0, h);
        rst = 1'b1;
        #1;
        check("mid_rst_up", 32'(up0), 32'd0);
        check("mid_rst_web", 32'(web0), 32'd1);
        check("mid_rst_ready", 32'(ready0), 32'd0);
        check("mid_rst_addr", 32'(addr0), 32'd0);
        check("mid_rst_data", datai0, 32'd0);
        @(posedge clk); #1;
        check("mid_rst_done", 32'(done0), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        clear_mon0();
        pulse_start(1'b0, sc);
        load0(1'b0);
        wait_done(1'b0, dc);
        @(posedge clk); #1;
        verify0("reload", sc, 1'b0);

        // WORDS=1 boundary, then restart on the done cycle
        w1_cnt = 0;
        d1_cnt = 0;
        pulse_start(1'b1, sc);
        send_byte(1'b1, 8'hAA, 1'b0, h);
        send_byte(1'b1, 8'hBB, 1'b0, h);
        send_byte(1'b1, 8'hCC, 1'b0, h);
        send_byte(1'b1, 8'hDD, 1'b0, h);
        wait_done(1'b1, dc);
        check("w1_done_cyc", 32'(dc), 32'(sc + 6));
        pulse_start(1'b1, sc2);
        check("w1_restart_up", 32'(up1), 32'd1);
        check("w1_restart_ready", 32'(ready1), 32'd1);
        check("w1_nwrites", 32'(w1_cnt), 32'd1);
        check("w1_addr", 32'(w1_addr), 32'd0);
        check("w1_data", w1_data, 32'hAABBCCDD);
        check("w1_wcyc", 32'(w1_cyc), 32'(sc + 4));
        check("w1_done_cnt", 32'(d1_cnt), 32'd1);
        w1_cnt = 0;
        d1_cnt = 0;
        send_byte(1'b1, 8'h12, 1'b0, h);
        send_byte(1'b1, 8'h34, 1'b0, h);
        send_byte(1'b1, 8'h56, 1'b0, h);
        send_byte(1'b1, 8'h78, 1'b0, h);
        wait_done(1'b1, dc);
        @(posedge clk); #1;
        check("w1b_done_cyc", 32'(dc), 32'(sc2 + 6));
        check("w1b_nwrites", 32'(w1_cnt), 32'd1);
        check("w1b_addr", 32'(w1_addr), 32'd0);
        check("w1b_data", w1_data, 32'h12345678);
        check("w1b_done_cnt", 32'(d1_cnt), 32'd1);
        check("w1b_idle_up", 32'(up1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boot_stream_loader.md
# boot_stream_loader

Upstream feeder for the CPU `top` boot port. It receives instruction bytes over a byte-wide valid/ready stream and packs them into 32-bit words. It then drives `boot_up`/`boot_addr`/`boot_datai`/`boot_web` to write those words into instruction memory at consecutive addresses. At the end it releases `boot_up` so the core starts executing from address 0.

## Interface
- `WORDS`, default 32: number of instruction words loaded per boot (1..256).
- `ADDR_W`, default 8: width of `boot_addr`.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a boot load; honoured only in IDLE.
- `byte_valid`  in  1  upstream byte present.
- `byte_data`  in  8  instruction byte; the first byte of each word is bits [31:24].
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `boot_up`  out  1  high for the whole load; holds the core in boot mode.
- `boot_addr`  out  ADDR_W  instruction memory word address.
- `boot_datai`  out  32  instruction word to write.
- `boot_web`  out  1  active-low write strobe.
- `done`  out  1  one-cycle pulse when the load completes.

## Operation
- States: IDLE, LOAD, WRITE, FINISH.
- **IDLE**
  - Outputs at rest values.
  - `start`=1 → LOAD; `boot_up`←1; word index←0; byte count←0.
- **LOAD**
  - `byte_ready`=1.
  - Each handshake (`byte_valid`&`byte_ready`) shifts the byte into the word buffer: buf←{buf[23:0],byte_data}; byte count+1.
  - On the 4th accepted byte → WRITE.
- **WRITE** (exactly one cycle)
  - `byte_ready`=0; `boot_web`=0; `boot_addr`=word index; `boot_datai`=packed word.
  - If index==WORDS-1 → FINISH; otherwise index+1, byte count←0, → LOAD.
- **FINISH** (one cycle)
  - `boot_up`=1, `boot_web`=1, `boot_addr`=0, `boot_datai`=0.
  - → IDLE; `boot_up` drops and `done`=1 in the IDLE-entry cycle.
- Index and byte counters do not wrap within a load. Index is compared against WORDS-1 and never exceeds it.
- `start` outside IDLE is ignored. `start` in the same cycle as `done` is accepted (a new load begins).
- Upstream may hold `byte_valid` high continuously. Bytes presented during WRITE/FINISH/IDLE are not consumed and must be held by upstream.
- `byte_data` is sampled only on a handshake.

## Timing
- All outputs are registered; none are combinational from inputs.
- Reset values: `boot_up`=0, `boot_web`=1, `boot_addr`=0, `boot_datai`=0, `byte_ready`=0, `done`=0; state IDLE; counters 0.
- Sequence:
  - `start` at cycle t → `boot_up`=1 and `byte_ready`=1 at t+1.
  - 4th byte handshake at cycle c → `boot_web`=0 with valid addr/data during c+1 only.
  - `byte_ready` returns to 1 at c+2.
- Throughput with back-to-back bytes: 5 cycles per word. Full load = 5·WORDS+1 cycles from `start` to `boot_up` fall.
- `boot_addr`/`boot_datai` are stable for the whole `boot_web`=0 cycle. Between writes they hold their last values. They are zero only in IDLE/FINISH.
- Reset mid-load aborts immediately:
  - all outputs return to reset values asynchronously;
  - the partial word is discarded;
  - no `done` pulse.

## Structure
- Shared package `boot_pkg`:
  - state enum (IDLE/LOAD/WRITE/FINISH);
  - `BOOT_WORD_W`=32;
  - `BOOT_BYTES_PER_WORD`=4;
  - default `BOOT_WORDS`=32.
- One sub-module, `boot_byte_packer`: 32-bit shift buffer plus 2-bit byte counter, with a `full` flag and `clear` input.
- The top-level FSM owns the word index and output registers.

## Test plan
- **Nominal load:** reset, `start`, stream 128 bytes back-to-back with WORDS=32 →
  - 32 single-cycle `boot_web`=0 pulses at addr 0..31, 5 cycles apart;
  - word k = bytes 4k..4k+3 MSB-first, e.g. bytes 00 00 00 0F → 0x0000000F at addr 0;
  - `boot_up` high for 161 cycles, then `done` pulse.
- **Throttled upstream:** `byte_valid` toggled randomly → identical write contents/addresses; `boot_web` low only after each 4th handshake.
- **Ignored start:** `start` pulsed during LOAD and WRITE → no counter reset, load completes normally.
- **Reset mid-word:** assert `rst` after 2 bytes of word 5 → outputs at reset values next edge; new `start` rewrites from addr 0.
- **Boundary:** WORDS=1 → single write at addr 0, FINISH, `done` 6 cycles after the cycle following `start`.
- **Restart:** `start` coincident with `done` → second load begins, `boot_up` re-asserts the next cycle.
